// File: rtl/pps_pkg.sv
// Shared types and period-bound helpers for the PPS sync controller.
package pps_pkg;

  typedef enum logic [1:0] {
    SRC_UNLOCKED = 2'd0,
    SRC_LOCKED   = 2'd1,
    SRC_HOLDOVER = 2'd2
  } pps_src_state_t;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ARMED = 2'd1,
    SCHED_DELAY = 2'd2
  } pps_sched_state_t;

  function automatic int unsigned period_lo(input int unsigned freq, input int unsigned tol);
    return (freq > tol) ? freq - tol : 0;
  endfunction

  function automatic int unsigned period_hi(input int unsigned freq, input int unsigned tol);
    return freq + tol;
  endfunction

  // One past the upper bound: the saturation point and the timeout threshold.
  function automatic int unsigned period_sat(input int unsigned freq, input int unsigned tol);
    return freq + tol + 1;
  endfunction

  function automatic int unsigned period_cnt_width(input int unsigned freq, input int unsigned tol);
    return $clog2(freq + tol + 2);
  endfunction

endpackage

// File: rtl/pps_period_checker.sv
// Cycles-since-last-PPS counter with good/short classification at the flag
// and a timeout when the counter first reaches saturation.
module pps_period_checker
  import pps_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 125000000,
  parameter int unsigned TOLERANCE = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic pps_flag,
  output logic good,
  output logic short_period,
  output logic timeout_next,
  output logic timeout
);

  localparam int unsigned CW = period_cnt_width(CLK_FREQ, TOLERANCE);
  localparam logic [CW-1:0] LO     = CW'(period_lo(CLK_FREQ, TOLERANCE));
  localparam logic [CW-1:0] HI     = CW'(period_hi(CLK_FREQ, TOLERANCE));
  localparam logic [CW-1:0] SAT    = CW'(period_sat(CLK_FREQ, TOLERANCE));
  localparam logic [CW-1:0] SAT_M1 = CW'(period_sat(CLK_FREQ, TOLERANCE) - 1);

  logic [CW-1:0] cnt;

  assign good         = pps_flag && (cnt >= LO) && (cnt <= HI);
  assign short_period = pps_flag && (cnt < LO);
  assign timeout_next = !pps_flag && (cnt == SAT_M1);

  // The flag cycle is the first cycle of the new period, so a flag N cycles
  // after the previous one sees cnt == N.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= SAT;
      timeout <= 1'b0;
    end else begin
      timeout <= timeout_next;
      if (pps_flag)
        cnt <= CW'(1);
      else if (cnt != SAT)
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pps_sync_controller.sv
// PPS lock/holdover control, holdoff writes, seconds counter and one-shot
// trigger scheduler for the PPS core, all in its ext clock domain.
//
// state         | meaning
// SRC_UNLOCKED  | collecting consecutive good periods
// SRC_LOCKED    | external PPS qualified, core uses it
// SRC_HOLDOVER  | PPS lost, core runs on its internal PPS
// SCHED_IDLE    | no trigger pending
// SCHED_ARMED   | waiting for the PPS that starts the target second
// SCHED_DELAY   | counting down the offset after that PPS
module pps_sync_controller
  import pps_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 125000000,
  parameter int unsigned TOLERANCE       = 1024,
  parameter int unsigned LOCK_COUNT      = 3,
  parameter int unsigned SEC_WIDTH       = 32,
  parameter int unsigned OFFSET_WIDTH    = 27,
  parameter logic [7:0]  DEFAULT_HOLDOFF = 8'd10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    pps_flag_i,
  input  logic                    auto_fallback_i,
  output logic                    int_sel_o,
  input  logic [7:0]              holdoff_i,
  input  logic                    holdoff_load_i,
  output logic [7:0]              holdoff_o,
  output logic                    holdoff_wr_o,
  output logic [SEC_WIDTH-1:0]    sec_o,
  output logic                    locked_o,
  output logic                    pps_missing_o,
  input  logic                    arm_i,
  input  logic [SEC_WIDTH-1:0]    arm_sec_i,
  input  logic [OFFSET_WIDTH-1:0] arm_offset_i,
  input  logic                    disarm_i,
  output logic                    armed_o,
  output logic                    arm_err_o,
  output logic                    trig_o
);

  localparam int unsigned GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam logic [GW-1:0] GC_LAST = GW'(LOCK_COUNT - 1);

  logic good, short_period, timeout_next, timeout;

  pps_period_checker #(
    .CLK_FREQ  (CLK_FREQ),
    .TOLERANCE (TOLERANCE)
  ) u_period (
    .clk          (clk_i),
    .rst          (rst_i),
    .pps_flag     (pps_flag_i),
    .good         (good),
    .short_period (short_period),
    .timeout_next (timeout_next),
    .timeout      (timeout)
  );

  pps_src_state_t src_q, src_next;
  logic [GW-1:0]  gc_q, gc_next;

  // A flag in the same cycle as the timeout takes precedence over it.
  always_comb begin
    src_next = src_q;
    gc_next  = gc_q;
    case (src_q)
      SRC_UNLOCKED: begin
        if (pps_flag_i) begin
          if (!good)
            gc_next = '0;
          else if (gc_q == GC_LAST)
            src_next = SRC_LOCKED;
          else
            gc_next = gc_q + GW'(1);
        end
      end
      SRC_LOCKED: begin
        if (pps_flag_i) begin
          if (short_period)
            src_next = SRC_UNLOCKED;
        end else if (timeout) begin
          src_next = auto_fallback_i ? SRC_HOLDOVER : SRC_UNLOCKED;
        end
      end
      SRC_HOLDOVER: begin
        if (!auto_fallback_i)
          src_next = SRC_UNLOCKED;
      end
      default: src_next = SRC_UNLOCKED;
    endcase
    if (src_next != src_q)
      gc_next = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q         <= SRC_UNLOCKED;
      gc_q          <= '0;
      locked_o      <= 1'b0;
      int_sel_o     <= 1'b0;
      pps_missing_o <= 1'b0;
      sec_o         <= '0;
    end else begin
      src_q         <= src_next;
      gc_q          <= gc_next;
      locked_o      <= (src_next == SRC_LOCKED);
      int_sel_o     <= (src_next == SRC_HOLDOVER);
      pps_missing_o <= (src_q == SRC_LOCKED) && timeout_next;
      if (pps_flag_i)
        sec_o <= sec_o + SEC_WIDTH'(1);
    end
  end

  // init_pend makes the core pick up the default holdoff right after reset.
  logic init_pend;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      init_pend    <= 1'b1;
      holdoff_o    <= DEFAULT_HOLDOFF;
      holdoff_wr_o <= 1'b0;
    end else begin
      init_pend    <= 1'b0;
      holdoff_wr_o <= init_pend || holdoff_load_i;
      if (holdoff_load_i)
        holdoff_o <= holdoff_i;
    end
  end

  pps_sched_state_t        sched_q, sched_next;
  logic [SEC_WIDTH-1:0]    tgt_q, tgt_next;
  logic [OFFSET_WIDTH-1:0] dly_q, dly_next;
  logic                    trig_next, err_next, sec_match;

  assign sec_match = pps_flag_i && ((sec_o + SEC_WIDTH'(1)) == tgt_q);

  // dly_q holds the raw offset while ARMED and the remaining count in DELAY.
  always_comb begin
    sched_next = sched_q;
    tgt_next   = tgt_q;
    dly_next   = dly_q;
    trig_next  = 1'b0;
    err_next   = 1'b0;
    if (disarm_i) begin
      sched_next = SCHED_IDLE;
    end else begin
      case (sched_q)
        SCHED_IDLE: begin
          if (arm_i) begin
            sched_next = SCHED_ARMED;
            tgt_next   = arm_sec_i;
            dly_next   = arm_offset_i;
          end
        end
        SCHED_ARMED: begin
          err_next = arm_i;
          if (sec_match) begin
            if (dly_q == '0) begin
              trig_next  = 1'b1;
              sched_next = SCHED_IDLE;
            end else begin
              dly_next   = dly_q - OFFSET_WIDTH'(1);
              sched_next = SCHED_DELAY;
            end
          end
        end
        SCHED_DELAY: begin
          err_next = arm_i;
          if (dly_q == '0) begin
            trig_next  = 1'b1;
            sched_next = SCHED_IDLE;
          end else begin
            dly_next = dly_q - OFFSET_WIDTH'(1);
          end
        end
        default: sched_next = SCHED_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sched_q   <= SCHED_IDLE;
      tgt_q     <= '0;
      dly_q     <= '0;
      armed_o   <= 1'b0;
      arm_err_o <= 1'b0;
      trig_o    <= 1'b0;
    end else begin
      sched_q   <= sched_next;
      tgt_q     <= tgt_next;
      dly_q     <= dly_next;
      armed_o   <= (sched_next != SCHED_IDLE);
      arm_err_o <= err_next;
      trig_o    <= trig_next;
    end
  end

endmodule

// File: tb/tb_pps_sync_controller.sv
// Self-checking bench for pps_sync_controller: scenario tasks with randomized
// PPS spacing, offsets and holdoff values against a timestamp-based model.
module tb_pps_sync_controller;

  localparam int CF  = 1000;
  localparam int TOL = 10;
  localparam int LC  = 3;
  localparam int SW  = 32;
  localparam int OW  = 27;
  localparam int SAT = CF + TOL + 1;

  logic clk = 1'b0;
  logic rst, pps_flag, auto_fallback, holdoff_load, arm, disarm;
  logic [7:0]    holdoff_in;
  logic [SW-1:0] arm_sec;
  logic [OW-1:0] arm_offset;
  logic int_sel, holdoff_wr, locked, pps_missing, armed, arm_err, trig;
  logic [7:0]    holdoff;
  logic [SW-1:0] sec;

  int checks = 0;
  int passes = 0;

  pps_sync_controller #(
    .CLK_FREQ(CF), .TOLERANCE(TOL), .LOCK_COUNT(LC), .SEC_WIDTH(SW),
    .OFFSET_WIDTH(OW), .DEFAULT_HOLDOFF(8'd10)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pps_flag_i(pps_flag), .auto_fallback_i(auto_fallback),
    .int_sel_o(int_sel), .holdoff_i(holdoff_in), .holdoff_load_i(holdoff_load),
    .holdoff_o(holdoff), .holdoff_wr_o(holdoff_wr), .sec_o(sec), .locked_o(locked),
    .pps_missing_o(pps_missing), .arm_i(arm), .arm_sec_i(arm_sec),
    .arm_offset_i(arm_offset), .disarm_i(disarm), .armed_o(armed),
    .arm_err_o(arm_err), .trig_o(trig)
  );

  always #5 clk = ~clk;

  // Reference model: cycle index of every input interval, time of the last
  // flag, and the source/scheduler situation expressed in those timestamps.
  longint        cyc = 0;
  longint        last_flag = 0;
  bit            lf_valid = 0;
  int            m_src = 0;   // 0 unlocked, 1 locked, 2 holdover
  int            m_gc = 0;
  logic [SW-1:0] m_sec = '0;
  logic [7:0]    m_hold = 8'd10;
  bit            m_wr = 0, m_pend = 1;
  bit            m_armed = 0, m_trig = 0, m_err = 0;
  logic [SW-1:0] m_tgt = '0;
  longint        m_off = 0, trig_at = -1;

  task automatic model_advance();
    longint age;
    bit good, short_p, tmo, was_armed;
    int nsrc;
    if (rst) begin
      lf_valid = 0; m_src = 0; m_gc = 0; m_sec = '0; m_hold = 8'd10;
      m_wr = 0; m_pend = 1; m_armed = 0; m_trig = 0; m_err = 0; trig_at = -1;
    end else begin
      age     = cyc - last_flag;
      good    = lf_valid && age >= CF - TOL && age <= CF + TOL;
      short_p = lf_valid && age < CF - TOL;
      tmo     = lf_valid && age == SAT && !pps_flag;
      nsrc    = m_src;
      case (m_src)
        0: if (pps_flag) begin
             if (good) begin
               m_gc++;
               if (m_gc == LC) nsrc = 1;
             end else m_gc = 0;
           end
        1: if (pps_flag) begin
             if (short_p) nsrc = 0;
           end else if (tmo) nsrc = auto_fallback ? 2 : 0;
        default: if (!auto_fallback) nsrc = 0;
      endcase
      if (nsrc != m_src) m_gc = 0;
      m_src = nsrc;
      m_trig = 0; m_err = 0; was_armed = m_armed;
      if (disarm) begin
        m_armed = 0; trig_at = -1;
      end else begin
        if (arm) begin
          if (was_armed) m_err = 1;
          else begin m_armed = 1; m_tgt = arm_sec; m_off = longint'(arm_offset); trig_at = -1; end
        end
        if (was_armed && trig_at < 0 && pps_flag && (m_sec + 1) == m_tgt)
          trig_at = cyc + m_off + 1;
      end
      if (m_armed && trig_at == cyc + 1) begin m_trig = 1; m_armed = 0; trig_at = -1; end
      if (pps_flag) begin m_sec++; last_flag = cyc; lf_valid = 1; end
      m_wr = m_pend || holdoff_load;
      if (holdoff_load) m_hold = holdoff_in;
      m_pend = 0;
    end
    cyc++;
  endtask

  task automatic step();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  // Flag lands n cycles after the previous flag; returns one cycle after it.
  task automatic pps_after(input int n);
    for (int i = 0; i < n - 1; i++) step();
    pps_flag = 1'b1;
    step();
    pps_flag = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({locked, int_sel, pps_missing, armed, arm_err, trig, holdoff_wr} !== 7'b0)
      $display("FAIL reset_flags: got %b expected 0000000",
               {locked, int_sel, pps_missing, armed, arm_err, trig, holdoff_wr});
    else passes++;
    checks++;
    if (sec !== '0 || holdoff !== 8'd10)
      $display("FAIL reset_values: sec=%0d holdoff=%0d expected 0/10", sec, holdoff);
    else passes++;
    rst = 1'b0;
    step();
    checks++;
    if (holdoff_wr !== 1'b1 || holdoff !== 8'd10)
      $display("FAIL init_holdoff_wr: wr=%b holdoff=%0d expected 1/10", holdoff_wr, holdoff);
    else passes++;
    step();
    checks++;
    if (holdoff_wr !== 1'b0)
      $display("FAIL init_holdoff_once: wr=%b expected 0", holdoff_wr);
    else passes++;
  endtask

  task automatic test_lock();
    pps_after($urandom_range(100, 900));
    pps_after(1000);
    pps_after(1000);
    checks++;
    if (locked !== 1'b0) $display("FAIL lock_early: locked=%b expected 0", locked);
    else passes++;
    pps_after(1000);
    checks++;
    if (locked !== 1'b1 || int_sel !== 1'b0)
      $display("FAIL lock_4th: locked=%b int_sel=%b expected 1/0", locked, int_sel);
    else passes++;
    checks++;
    if (sec !== 32'd4) $display("FAIL lock_sec: sec=%0d expected 4", sec);
    else passes++;
  endtask

  // Must be entered one cycle after a flag while locked.
  task automatic test_missing(input bit fb);
    int k = 1;
    auto_fallback = fb;
    while (pps_missing !== 1'b1 && k < SAT + 50) begin step(); k++; end
    checks++;
    if (k != SAT) $display("FAIL missing_time: got %0d cycles expected %0d", k, SAT);
    else passes++;
    checks++;
    if (pps_missing !== m_src[0] || int_sel !== 1'b0)
      $display("FAIL missing_pulse: missing=%b int_sel=%b expected 1/0", pps_missing, int_sel);
    else passes++;
    step();
    checks++;
    if (int_sel !== fb || locked !== 1'b0 || pps_missing !== 1'b0)
      $display("FAIL after_missing: int_sel=%b locked=%b missing=%b expected %b/0/0",
               int_sel, locked, pps_missing, fb);
    else passes++;
  endtask

  task automatic test_holdover_exit();
    repeat (20) step();
    checks++;
    if (int_sel !== 1'b1) $display("FAIL holdover_hold: int_sel=%b expected 1", int_sel);
    else passes++;
    auto_fallback = 1'b0;
    step();
    checks++;
    if (int_sel !== 1'b0 || locked !== 1'b0)
      $display("FAIL holdover_exit: int_sel=%b locked=%b expected 0/0", int_sel, locked);
    else passes++;
    auto_fallback = 1'b1;
  endtask

  task automatic test_relock();
    pps_after($urandom_range(50, 500));
    repeat (LC) pps_after($urandom_range(CF - TOL, CF + TOL));
    checks++;
    if (locked !== 1'b1 || m_src != 1) $display("FAIL relock: locked=%b expected 1", locked);
    else passes++;
  endtask

  task automatic test_short();
    pps_after(985);
    checks++;
    if (locked !== 1'b0) $display("FAIL short_unlock: locked=%b expected 0", locked);
    else passes++;
    pps_after(1000);
    pps_after(1000);
    checks++;
    if (locked !== 1'b0) $display("FAIL short_early: locked=%b expected 0", locked);
    else passes++;
    pps_after(1000);
    checks++;
    if (locked !== 1'b1) $display("FAIL short_relock: locked=%b expected 1", locked);
    else passes++;
  endtask

  task automatic test_random_periods();
    for (int i = 0; i < 12; i++) begin
      auto_fallback = ($urandom_range(0, 3) != 0);
      pps_after($urandom_range(970, 1030));
      checks++;
      if (locked !== (m_src == 1) || int_sel !== (m_src == 2) || sec !== m_sec)
        $display("FAIL rand_period_%0d: locked=%b int_sel=%b sec=%0d expected %b/%b/%0d",
                 i, locked, int_sel, sec, m_src == 1, m_src == 2, m_sec);
      else passes++;
    end
    auto_fallback = 1'b1;
  endtask

  task automatic test_holdoff();
    holdoff_load = 1'b1; holdoff_in = 8'h40;
    step();
    checks++;
    if (holdoff_wr !== 1'b1 || holdoff !== 8'h40)
      $display("FAIL holdoff_first: wr=%b val=%h expected 1/40", holdoff_wr, holdoff);
    else passes++;
    holdoff_in = 8'h41;
    step();
    holdoff_load = 1'b0;
    checks++;
    if (holdoff_wr !== 1'b1 || holdoff !== 8'h41)
      $display("FAIL holdoff_second: wr=%b val=%h expected 1/41", holdoff_wr, holdoff);
    else passes++;
    step();
    checks++;
    if (holdoff_wr !== 1'b0 || holdoff !== 8'h41)
      $display("FAIL holdoff_idle: wr=%b val=%h expected 0/41", holdoff_wr, holdoff);
    else passes++;
    for (int i = 0; i < 6; i++) begin
      holdoff_load = 1'($urandom_range(0, 1)); holdoff_in = 8'($urandom);
      step();
      checks++;
      if (holdoff_wr !== m_wr || holdoff !== m_hold)
        $display("FAIL holdoff_rand_%0d: wr=%b val=%h expected %b/%h", i, holdoff_wr, holdoff, m_wr, m_hold);
      else passes++;
    end
    holdoff_load = 1'b0;
  endtask

  task automatic test_schedule();
    int k = 1;
    logic [SW-1:0] tgt;
    tgt = sec + 3;
    arm = 1'b1; arm_sec = tgt; arm_offset = 27'd100;
    step();
    arm = 1'b0;
    checks++;
    if (armed !== 1'b1) $display("FAIL arm: armed=%b expected 1", armed);
    else passes++;
    pps_after(1000);
    arm = 1'b1; arm_sec = sec + 1; arm_offset = 27'd7;
    step();
    arm = 1'b0;
    checks++;
    if (arm_err !== 1'b1 || armed !== 1'b1)
      $display("FAIL arm_err: err=%b armed=%b expected 1/1", arm_err, armed);
    else passes++;
    pps_after(1000);
    pps_after(1000);
    while (trig !== 1'b1 && k < 300) begin step(); k++; end
    checks++;
    if (k != 101) $display("FAIL trig_time: got %0d cycles expected 101", k);
    else passes++;
    checks++;
    if (armed !== 1'b0 || sec !== tgt)
      $display("FAIL trig_state: armed=%b sec=%0d expected 0/%0d", armed, sec, tgt);
    else passes++;
    step();
    checks++;
    if (trig !== 1'b0) $display("FAIL trig_width: trig=%b expected 0", trig);
    else passes++;
  endtask

  task automatic test_offsets();
    for (int i = 0; i < 4; i++) begin
      int off, k;
      off = (i == 0) ? 0 : $urandom_range(1, 400);
      k = 1;
      arm = 1'b1; arm_sec = sec + 1; arm_offset = OW'(off);
      step();
      arm = 1'b0;
      pps_after($urandom_range(500, 1000));
      while (trig !== 1'b1 && k < off + 50) begin step(); k++; end
      checks++;
      if (k != off + 1 || trig !== m_trig)
        $display("FAIL offset_%0d: trig after %0d cycles expected %0d", off, k, off + 1);
      else passes++;
    end
  endtask

  task automatic test_disarm();
    bit saw = 0;
    arm = 1'b1; arm_sec = sec + 1; arm_offset = 27'd300;
    step();
    arm = 1'b0;
    pps_after(1000);
    repeat (50) step();
    checks++;
    if (armed !== 1'b1) $display("FAIL delay_armed: armed=%b expected 1", armed);
    else passes++;
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    checks++;
    if (armed !== 1'b0) $display("FAIL disarm: armed=%b expected 0", armed);
    else passes++;
    repeat (400) begin step(); if (trig === 1'b1) saw = 1; end
    checks++;
    if (saw) $display("FAIL disarm_trig: trig seen=%b expected 0", saw);
    else passes++;
    arm = 1'b1; disarm = 1'b1; arm_sec = sec + 1;
    step();
    arm = 1'b0; disarm = 1'b0;
    checks++;
    if (armed !== 1'b0 || arm_err !== 1'b0)
      $display("FAIL disarm_override: armed=%b err=%b expected 0/0", armed, arm_err);
    else passes++;
  endtask

  task automatic test_midreset();
    arm = 1'b1; arm_sec = sec + 1; arm_offset = 27'd500;
    step();
    arm = 1'b0;
    pps_after(1000);
    repeat (10) step();
    rst = 1'b1;
    step();
    checks++;
    if ({locked, int_sel, pps_missing, armed, arm_err, trig, holdoff_wr} !== 7'b0 ||
        sec !== '0 || holdoff !== 8'd10)
      $display("FAIL midreset: flags=%b sec=%0d holdoff=%0d expected 0/0/10",
               {locked, int_sel, pps_missing, armed, arm_err, trig, holdoff_wr}, sec, holdoff);
    else passes++;
    rst = 1'b0;
    step();
    checks++;
    if (holdoff_wr !== 1'b1 || holdoff !== m_hold)
      $display("FAIL midreset_wr: wr=%b holdoff=%0d expected 1/%0d", holdoff_wr, holdoff, m_hold);
    else passes++;
  endtask

  initial begin
    rst = 1'b1; pps_flag = 1'b0; auto_fallback = 1'b1; holdoff_load = 1'b0;
    holdoff_in = '0; arm = 1'b0; disarm = 1'b0; arm_sec = '0; arm_offset = '0;
    test_reset();
    test_lock();
    test_missing(1'b1);
    test_holdover_exit();
    test_relock();
    test_short();
    test_missing(1'b0);
    test_random_periods();
    test_holdoff();
    test_schedule();
    test_offsets();
    test_disarm();
    test_midreset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pps_sync_controller.md
# pps_sync_controller

Controller for the PPS core in the `ext_clk` domain. It qualifies incoming PPS flags against the nominal period and runs the lock/holdover state machine that drives the core's internal-PPS select. It also owns the holdoff configuration writes and keeps a seconds counter. A one-shot scheduler fires a trigger pulse at a programmed second plus a clock offset.

## Interface
- `CLK_FREQ`, 125000000: nominal `clk_i` cycles per second.
- `TOLERANCE`, 1024: allowed period deviation in cycles, ±.
- `LOCK_COUNT`, 3: consecutive good PPS periods required to lock.
- `SEC_WIDTH`, 32: seconds counter width.
- `OFFSET_WIDTH`, 27: trigger offset width; must hold `CLK_FREQ-1`.
- `DEFAULT_HOLDOFF`, 10: holdoff value written after reset.

Ports:
- `clk_i` in 1: single clock; the PPS core's ext clock.
- `rst_i` in 1: synchronous, active-high reset.
- `pps_flag_i` in 1: PPS flag from the core, one-cycle pulse.
- `auto_fallback_i` in 1: allows entry to holdover on a lost PPS.
- `int_sel_o` out 1: internal PPS select to the core.
- `holdoff_i` in 8: new holdoff value.
- `holdoff_load_i` in 1: request a holdoff write.
- `holdoff_o` out 8: holdoff value to the core.
- `holdoff_wr_o` out 1: holdoff write strobe to the core.
- `sec_o` out SEC_WIDTH: seconds counter.
- `locked_o` out 1: state is LOCKED.
- `pps_missing_o` out 1: one-cycle pulse on a period timeout.
- `arm_i` in 1: arm the scheduler.
- `arm_sec_i` in SEC_WIDTH: target second.
- `arm_offset_i` in OFFSET_WIDTH: delay after the target PPS, in cycles.
- `disarm_i` in 1: cancel an armed trigger.
- `armed_o` out 1: a trigger is pending.
- `arm_err_o` out 1: one-cycle pulse when `arm_i` arrives while already armed.
- `trig_o` out 1: one-cycle trigger pulse.

## Operation
**Period counter**
- Counts cycles since the last `pps_flag_i` and saturates at `CLK_FREQ+TOLERANCE+1`.
- Reset sets it to the saturated value, so the first PPS after reset is never "good".
- Cleared on `pps_flag_i`.
- A period is **good** when it lies in `[CLK_FREQ-TOLERANCE, CLK_FREQ+TOLERANCE]` at the flag.
- **Timeout** is the cycle the counter first reaches `CLK_FREQ+TOLERANCE+1` from below.

**Source FSM (UNLOCKED, LOCKED, HOLDOVER)**
- Reset state is UNLOCKED; `int_sel_o` is 1 only in HOLDOVER.
- UNLOCKED:
  - Good flag increments `good_cnt`; any other flag clears it.
  - When `good_cnt` reaches `LOCK_COUNT`, go to LOCKED.
- LOCKED:
  - Timeout pulses `pps_missing_o`, then goes to HOLDOVER if `auto_fallback_i`, else UNLOCKED.
  - A flag with a short period goes to UNLOCKED.
- HOLDOVER:
  - Period checks are ignored.
  - `auto_fallback_i`=0 goes to UNLOCKED with `good_cnt` cleared.
- Every transition clears `good_cnt`.

**Seconds counter**
- `sec_o` increments on every `pps_flag_i` in every state and wraps modulo 2^SEC_WIDTH.

**Holdoff writes**
- `holdoff_o` resets to `DEFAULT_HOLDOFF`.
- `holdoff_wr_o` pulses in the first cycle after `rst_i` deasserts.
- `holdoff_load_i` latches `holdoff_i` into `holdoff_o` and pulses `holdoff_wr_o` the next cycle.
- Back-to-back loads give back-to-back strobes, each carrying its own value.

**Scheduler (IDLE, ARMED, DELAY)**
- IDLE: `arm_i` captures the target second and offset and moves to ARMED.
- ARMED: a `pps_flag_i` whose post-increment second equals the target loads the delay counter with the offset and moves to DELAY.
- DELAY: the delay counter decrements; `trig_o` pulses when it is zero, then return to IDLE.
- `armed_o` is 1 in ARMED and DELAY.
- `arm_i` while armed is ignored and pulses `arm_err_o`.
- `disarm_i` returns to IDLE from ARMED or DELAY and overrides `arm_i` in the same cycle.
- The scheduler is independent of lock state.

## Timing
- Reset values: `int_sel_o`=0, `locked_o`=0, `sec_o`=0, `holdoff_o`=`DEFAULT_HOLDOFF`, `holdoff_wr_o`=0, and all pulses and `armed_o` = 0.
- All outputs are registered.
- `sec_o` updates 1 cycle after `pps_flag_i`.
- FSM state, `locked_o` and `int_sel_o` update 1 cycle after the deciding flag or timeout.
- `trig_o` fires `arm_offset_i+1` cycles after the target `pps_flag_i` cycle; offset 0 gives 1 cycle.
- Simultaneous `pps_flag_i` and timeout: the flag wins.
- A PPS arriving during DELAY does not restart the delay counter.
- `rst_i` mid-operation returns every state to its reset value in the next cycle.

## Structure
- Shared package `pps_pkg`:
  - FSM enums `pps_src_state_t` and `pps_sched_state_t`.
  - Tolerance-bound calculation functions.
- Sub-module `pps_period_checker`: period counter plus good/short/timeout outputs, reusable for monitoring.

## Test plan
- Reset, then PPS every 1000 cycles (`CLK_FREQ`=1000, `TOLERANCE`=10, `LOCK_COUNT`=3):
  - `holdoff_wr_o` pulses once with `holdoff_o`=10.
  - `locked_o` rises 1 cycle after the 4th flag.
  - `sec_o`=4.
- Locked, then PPS stops with `auto_fallback_i`=1:
  - `pps_missing_o` pulses 1011 cycles after the last flag.
  - `int_sel_o`=1 the next cycle.
  - Repeat with `auto_fallback_i`=0: expect UNLOCKED and `int_sel_o`=0.
- Locked, PPS at 985 cycles: `locked_o` falls; 3 further 1000-cycle periods relock.
- Arm `arm_sec_i`=5, `arm_offset_i`=100 at `sec_o`=2:
  - `trig_o` pulses exactly 101 cycles after the flag that makes `sec_o`=5.
  - `armed_o` falls with it.
- Second `arm_i` while armed gives an `arm_err_o` pulse with the target unchanged; `disarm_i` during DELAY gives no trigger.
- `holdoff_load_i` with `holdoff_i`=0x40, then 0x41 the next cycle: two consecutive `holdoff_wr_o` strobes carrying 0x40 then 0x41.
